// File: rtl/ir_ctrl_if.sv
// Core-side handshake bundle of the interrupt controller: the request line,
// the acknowledge/end-of-interrupt strobes and the claim information.
// The controller uses the master modport and the core uses the slave modport.
interface ir_ctrl_if #(
  parameter int ID_W = 3
);
  logic            interrupter;
  logic            ir;
  logic            eoi;
  logic [ID_W-1:0] claim_id;
  logic            claim_valid;

  modport master (
    output interrupter,
    output claim_id,
    output claim_valid,
    input  ir,
    input  eoi
  );

  modport slave (
    input  interrupter,
    input  claim_id,
    input  claim_valid,
    output ir,
    output eoi
  );
endinterface

// File: rtl/ir_ctrl.sv
// Fixed-priority interrupt controller with a single outstanding claim.
// Source 0 has the highest priority. The pending vector is registered, and an
// IDLE/REQ/SERVICE FSM drives the request to the core and latches the claim
// on acknowledge.
// Optional feature macro: IR_EDGE_DETECT_EN. When it is defined, sources are
// rising-edge detected and latched until acknowledged. When it is undefined,
// the pending vector follows the enabled source levels.
module ir_ctrl #(
  parameter int NUM_SRC = 8,
  parameter int ID_W    = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic               en_wen,
  input  logic [NUM_SRC-1:0] en_din,
  output logic [NUM_SRC-1:0] en,
  output logic [NUM_SRC-1:0] pending,
  ir_ctrl_if.master          core
);

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  state_t             state;
  logic [NUM_SRC-1:0] en_next;
  logic [NUM_SRC-1:0] pending_next;
  logic [ID_W-1:0]    winner;
  logic               any_pending;
  logic               ack;

  // Lowest-index pending source wins; the scan runs downward so the lowest index is written last.
  always_comb begin
    winner = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (pending[i]) winner = ID_W'(i);
    end
  end

  // An acknowledge counts only in REQ while something is still pending.
  always_comb begin
    any_pending = |pending;
    ack         = (state == REQ) && core.ir && any_pending;
    en_next     = en_wen ? en_din : en;
  end

  // The enable register updates on the edge that follows a write, in every state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) en <= '0;
    else        en <= en_next;
  end

`ifdef IR_EDGE_DETECT_EN
  logic [NUM_SRC-1:0] irq_prev;
  logic [NUM_SRC-1:0] ack_mask;

  // A new rising edge beats the acknowledge clear, and clearing an enable drops its pending bit.
  always_comb begin
    ack_mask     = ack ? (NUM_SRC'(1) << winner) : '0;
    pending_next = ((pending & ~ack_mask) | (irq_src & ~irq_prev & en_next)) & en_next;
  end

  // Keep the previous source sample for the rising-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) irq_prev <= '0;
    else        irq_prev <= irq_src;
  end
`else
  // In level mode the pending vector is simply the enabled source levels.
  always_comb begin
    pending_next = irq_src & en_next;
  end
`endif

  // Register the pending vector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending <= '0;
    else        pending <= pending_next;
  end

  // Request/service FSM with registered interrupter, claim_valid and claim_id outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      core.interrupter <= 1'b0;
      core.claim_valid <= 1'b0;
      core.claim_id    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_pending) begin
            state            <= REQ;
            core.interrupter <= 1'b1;
          end
        end
        REQ: begin
          if (!any_pending) begin
            state            <= IDLE;
            core.interrupter <= 1'b0;
          end else if (ack) begin
            state            <= SERVICE;
            core.interrupter <= 1'b0;
            core.claim_valid <= 1'b1;
            core.claim_id    <= winner;
          end
        end
        SERVICE: begin
          if (core.eoi) begin
            state            <= IDLE;
            core.claim_valid <= 1'b0;
          end
        end
        default: begin
          state            <= IDLE;
          core.interrupter <= 1'b0;
          core.claim_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ir_ctrl.sv
// Self-checking bench for ir_ctrl. It runs a behavioural model in parallel
// with the design, and a claim scoreboard is popped by a separate monitor
// process.
module tb_ir_ctrl;
  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] irq_src;
  logic         en_wen;
  logic [N-1:0] en_din;
  logic [N-1:0] en;
  logic [N-1:0] pending;

  ir_ctrl_if #(.ID_W(3)) core_if ();

  ir_ctrl #(.NUM_SRC(N), .ID_W(3)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .irq_src (irq_src),
    .en_wen  (en_wen),
    .en_din  (en_din),
    .en      (en),
    .pending (pending),
    .core    (core_if)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Model state: 0 = waiting, 1 = requesting, 2 = being serviced.
  int         m_phase;
  logic [N-1:0] m_en, m_pend, m_prev;
  logic [2:0] m_claim;
  int         exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int lowest(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_en = '0; m_pend = '0; m_prev = '0; m_claim = '0;
  endtask

  task automatic check_output();
    check("en",          32'(en),                  32'(m_en));
    check("pending",     32'(pending),             32'(m_pend));
    check("interrupter", 32'(core_if.interrupter), 32'(m_phase == 1));
    check("claim_valid", 32'(core_if.claim_valid), 32'(m_phase == 2));
    check("claim_id",    32'(core_if.claim_id),    32'(m_claim));
  endtask

  // Predict what the coming rising edge does with the inputs just driven.
  task automatic predict(input logic [N-1:0] s, input logic w, input logic [N-1:0] d,
                         input logic a, input logic e);
    logic [N-1:0] en_new, p;
    bit acked;
    int win;
    en_new = w ? d : m_en;
    win    = lowest(m_pend);
    acked  = (m_phase == 1) && a && (m_pend != 0);
`ifdef IR_EDGE_DETECT_EN
    p = m_pend;
    if (acked) p[win] = 1'b0;
    p = (p | (s & ~m_prev & en_new)) & en_new;
`else
    p = s & en_new;
`endif
    if (m_phase == 0) begin
      if (m_pend != 0) m_phase = 1;
    end else if (m_phase == 1) begin
      if (m_pend == 0) m_phase = 0;
      else if (acked) begin
        m_phase = 2;
        m_claim = 3'(win);
        exp_q.push_back(win);
      end
    end else begin
      if (e) m_phase = 0;
    end
    m_prev = s;
    m_en   = en_new;
    m_pend = p;
  endtask

  task automatic apply_stimulus(input logic [N-1:0] s, input logic w, input logic [N-1:0] d,
                                input logic a, input logic e);
    @(negedge clk);
    check_output();
    irq_src = s; en_wen = w; en_din = d; core_if.ir = a; core_if.eoi = e;
    predict(s, w, d, a, e);
  endtask

  task automatic idle_cycles(input int n, input logic [N-1:0] s);
    for (int i = 0; i < n; i++) apply_stimulus(s, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic restore_en();
    apply_stimulus('0, 1'b1, '0, 1'b0, 1'b1);
    apply_stimulus('0, 1'b1, 8'hFF, 1'b0, 1'b1);
    idle_cycles(3, '0);
  endtask

  // Monitor: each new claim must match the oldest predicted acknowledge.
  logic cv_prev = 1'b0;
  always @(negedge clk) begin
    if (core_if.claim_valid && !cv_prev) begin
      if (exp_q.size() == 0) check("claim_unexpected", 32'(core_if.claim_id), 32'hFFFF_FFFF);
      else check("claim_id_sb", 32'(core_if.claim_id), 32'(exp_q.pop_front()));
    end
    cv_prev = core_if.claim_valid;
  end

  initial begin
    logic [N-1:0] s;
    bit reached;
    rst_n = 1'b0; irq_src = '0; en_wen = 1'b0; en_din = '0;
    core_if.ir = 1'b0; core_if.eoi = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_output();
    rst_n = 1'b1;

    // Enable every source, then pulse source 5 and acknowledge it.
    apply_stimulus('0, 1'b1, 8'hFF, 1'b0, 1'b0);
    idle_cycles(2, '0);
    apply_stimulus(8'h20, 1'b0, '0, 1'b0, 1'b0);
    idle_cycles(3, '0);
    apply_stimulus('0, 1'b0, '0, 1'b1, 1'b0);
    idle_cycles(2, '0);
    apply_stimulus('0, 1'b0, '0, 1'b0, 1'b1);
    idle_cycles(3, '0);

    // Sources 6 and 2 together: claim 2 first, then the next claim.
    idle_cycles(3, 8'h44);
    apply_stimulus(8'h44, 1'b0, '0, 1'b1, 1'b0);
    idle_cycles(2, 8'h44);
    apply_stimulus(8'h44, 1'b0, '0, 1'b0, 1'b1);
    idle_cycles(3, 8'h44);
    apply_stimulus(8'h44, 1'b0, '0, 1'b1, 1'b0);
    apply_stimulus('0, 1'b0, '0, 1'b0, 1'b1);
    restore_en();

    // Source 4 requests, then source 1 preempts before the acknowledge.
    idle_cycles(3, 8'h10);
    idle_cycles(2, 8'h12);
    apply_stimulus(8'h12, 1'b0, '0, 1'b1, 1'b0);
    apply_stimulus('0, 1'b0, '0, 1'b0, 1'b1);
    restore_en();

    // Masking everything during REQ withdraws the request; a late ir is ignored.
    idle_cycles(3, 8'h08);
    apply_stimulus(8'h08, 1'b1, '0, 1'b0, 1'b0);
    idle_cycles(2, 8'h08);
    apply_stimulus(8'h08, 1'b0, '0, 1'b1, 1'b0);
    idle_cycles(2, 8'h08);
    restore_en();

    // Source 3 held through eoi, then dropped before the second eoi.
    idle_cycles(3, 8'h08);
    apply_stimulus(8'h08, 1'b0, '0, 1'b1, 1'b0);
    apply_stimulus(8'h08, 1'b0, '0, 1'b0, 1'b1);
    idle_cycles(3, 8'h08);
    apply_stimulus(8'h08, 1'b0, '0, 1'b1, 1'b0);
    idle_cycles(2, '0);
    apply_stimulus('0, 1'b0, '0, 1'b0, 1'b1);
    idle_cycles(4, '0);
    restore_en();

    // Randomised traffic.
    s = '0;
    for (int i = 0; i < 1500; i++) begin
      logic w;
      logic [N-1:0] d;
      if ($urandom_range(0, 3) == 0) s[$urandom_range(0, N - 1)] ^= 1'b1;
      w = ($urandom_range(0, 29) == 0);
      d = N'($urandom | $urandom);
      apply_stimulus(s, w, d, 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 3) == 0));
    end

    // Drive into SERVICE, then reset asynchronously in the middle of the service.
    reached = 1'b0;
    for (int i = 0; i < 40 && !reached; i++) begin
      apply_stimulus(8'h01, 1'b1, 8'hFF, 1'(m_phase == 1), 1'b0);
      if (m_phase == 2) reached = 1'b1;
    end
    check("reach_service", 32'(reached), 32'd1);
    @(negedge clk);
    check_output();
    #2 rst_n = 1'b0;
    #1;
    check("rst_claim_valid", 32'(core_if.claim_valid), 32'd0);
    check("rst_interrupter", 32'(core_if.interrupter), 32'd0);
    check("rst_en",          32'(en),                  32'd0);
    check("rst_pending",     32'(pending),             32'd0);
    check("rst_claim_id",    32'(core_if.claim_id),    32'd0);
    model_reset();
    irq_src = '0; en_wen = 1'b0; core_if.ir = 1'b0; core_if.eoi = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    apply_stimulus('0, 1'b1, 8'hFF, 1'b1, 1'b1);
    idle_cycles(2, 8'h80);
    apply_stimulus(8'h80, 1'b0, '0, 1'b1, 1'b0);
    apply_stimulus('0, 1'b0, '0, 1'b0, 1'b1);
    idle_cycles(3, '0);

    @(negedge clk);
    #1;
    check_output();
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
